// File: rtl/apb_pkg.sv
// Shared types and constants for the APB subsystem: FSM states, bus widths
// and the request record the master latches at the start of each transfer.
package apb_pkg;

    localparam int ADDR_W        = 9;
    localparam int DATA_W        = 8;
    localparam int SLV_DEPTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_if.sv
// Request/response port bundle between the requesting logic (master modport)
// and the APB subsystem (slave modport).
interface apb_if;
    import apb_pkg::*;

    logic              transfer;
    logic              READ_WRITE;
    logic [ADDR_W-1:0] apb_write_paddr;
    logic [ADDR_W-1:0] apb_read_paddr;
    logic [DATA_W-1:0] apb_write_data;
    logic [DATA_W-1:0] apb_read_data_out;
    logic              PSLVERR;

    modport master (
        output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        input  apb_read_data_out, PSLVERR
    );

    modport slave (
        input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        output apb_read_data_out, PSLVERR
    );

endinterface

// File: rtl/apb_master.sv
// APB3 master: IDLE/SETUP/ACCESS sequencer with request registers that hold
// the transfer stable for its whole SETUP/ACCESS lifetime.
module apb_master
    import apb_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              transfer,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] write_paddr,
    input  logic [ADDR_W-1:0] read_paddr,
    input  logic [DATA_W-1:0] write_data,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    apb_state_t state_q, state_d;
    apb_req_t   req_q, req_d;
    logic       take_req;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        take_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d  = SETUP;
                    take_req = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // Slaves are zero-wait, so ACCESS always completes in one cycle.
                if (transfer) begin
                    state_d  = SETUP;
                    take_req = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take_req) begin
            req_d.write = !read_write;
            req_d.addr  = read_write ? read_paddr : write_paddr;
            req_d.wdata = write_data;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign pwrite  = req_q.write;
    assign paddr   = req_q.addr;
    assign pwdata  = req_q.wdata;

endmodule

// File: rtl/apb_slave.sv
// Zero-wait APB slave backed by a byte memory. The array is read during SETUP
// into a register so PRDATA is ready in ACCESS while keeping a RAM-style read.
module apb_slave
    import apb_pkg::*;
#(
    parameter int DEPTH = SLV_DEPTH_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        offset,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic              wr_en;

    assign err   = (32'(offset) >= 32'(DEPTH));
    assign idx   = offset[IDX_W-1:0];
    // A reset sampled in ACCESS aborts the transfer, so it must also block the write.
    assign wr_en = PRESETn && psel && penable && pwrite && !err;

    always_ff @(posedge PCLK) begin
        if (psel && !penable) begin
            rd_data_q <= mem[idx];
        end
        if (wr_en) begin
            mem[idx] <= pwdata;
        end
    end

    assign pready  = 1'b1;
    assign pslverr = psel && penable && err;
    assign prdata  = err ? '0 : rd_data_q;

endmodule

// File: rtl/apb_top.sv
// APB subsystem top: master FSM, two byte-memory slaves selected by address
// bit 8, and the registered read-data / error outputs.
module apb_top
    import apb_pkg::*;
#(
    parameter int SLV_DEPTH = SLV_DEPTH_DEF
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_if.slave bus
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

    logic [DATA_W-1:0] prdata_s  [2];
    logic              pready_s  [2];
    logic              pslverr_s [2];

    logic              slv_sel;
    logic              complete;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              pslverr_q, pslverr_d;

    apb_master u_master (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .transfer    (bus.transfer),
        .read_write  (bus.READ_WRITE),
        .write_paddr (bus.apb_write_paddr),
        .read_paddr  (bus.apb_read_paddr),
        .write_data  (bus.apb_write_data),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata)
    );

    assign slv_sel = paddr[ADDR_W-1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slv
            apb_slave #(.DEPTH(SLV_DEPTH)) u_slave (
                .PCLK    (PCLK),
                .PRESETn (PRESETn),
                .psel    (psel && (int'(slv_sel) == gi)),
                .penable (penable),
                .pwrite  (pwrite),
                .offset  (paddr[7:0]),
                .pwdata  (pwdata),
                .prdata  (prdata_s[gi]),
                .pready  (pready_s[gi]),
                .pslverr (pslverr_s[gi])
            );
        end
    endgenerate

    assign complete = psel && penable && pready_s[slv_sel];

    always_comb begin
        rd_data_d = rd_data_q;
        pslverr_d = pslverr_q;
        if (complete) begin
            pslverr_d = pslverr_s[slv_sel];
            if (!pwrite) begin
                rd_data_d = prdata_s[slv_sel];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rd_data_q <= '0;
            pslverr_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Forced low while reset is asserted so the first reset cycle already reads 0.
    assign bus.apb_read_data_out = PRESETn ? rd_data_q : '0;
    assign bus.PSLVERR           = PRESETn ? pslverr_q : 1'b0;

endmodule

// File: tb/tb_apb_top.sv
// Directed bench for apb_top: single transfers, slave isolation, out-of-range
// errors, back-to-back streaming and a reset that aborts a write in ACCESS.
module tb_apb_top;
    import apb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_if bus ();

    apb_top #(.SLV_DEPTH(64)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_rdata;
    logic       model_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // For reads, 'data' is the expected read data; the unused path carries junk.
    task automatic set_req(input logic rd, input logic [8:0] addr, input logic [7:0] data);
        bus.READ_WRITE = rd;
        if (rd) begin
            bus.apb_read_paddr  = addr;
            bus.apb_write_paddr = addr ^ 9'h1FF;
            bus.apb_write_data  = ~data;
        end else begin
            bus.apb_write_paddr = addr;
            bus.apb_read_paddr  = addr ^ 9'h1FF;
            bus.apb_write_data  = data;
        end
    endtask

    // Called #1 after an edge with the FSM idle; returns #1 after completion.
    task automatic do_op(input string tag, input logic rd, input logic [8:0] addr,
                         input logic [7:0] data, input logic exp_err);
        set_req(rd, addr, data);
        bus.transfer = 1'b1;
        @(posedge clk); #1;
        bus.transfer = 1'b0;
        set_req(~rd, ~addr, ~data);
        @(posedge clk); #1;
        check({tag, "_mid_data"}, 32'(bus.apb_read_data_out), 32'(model_rdata));
        check({tag, "_mid_err"}, 32'(bus.PSLVERR), 32'(model_err));
        @(posedge clk); #1;
        if (rd) model_rdata = exp_err ? 8'h00 : data;
        model_err = exp_err;
        check({tag, "_data"}, 32'(bus.apb_read_data_out), 32'(model_rdata));
        check({tag, "_err"}, 32'(bus.PSLVERR), 32'(model_err));
        $display("[TB] %s %s addr=0x%03h data=0x%02h err=%0b", tag, rd ? "RD" : "WR",
                 addr, bus.apb_read_data_out, bus.PSLVERR);
    endtask

    logic       b_rd   [4];
    logic [8:0] b_addr [4];
    logic [7:0] b_data [4];

    initial begin
        bus.transfer        = 1'b0;
        bus.READ_WRITE      = 1'b0;
        bus.apb_write_paddr = '0;
        bus.apb_read_paddr  = '0;
        bus.apb_write_data  = '0;
        model_rdata         = 8'h00;
        model_err           = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_data", 32'(bus.apb_read_data_out), 32'h0);
            check("rst_err", 32'(bus.PSLVERR), 32'h0);
        end
        check("rst_state", 32'(dut.u_master.state_q), 32'(IDLE));
        $display("[TB] reset held 3 cycles");
        rst_n = 1'b1;

        do_op("wr_005", 1'b0, 9'h005, 8'hA5, 1'b0);
        do_op("rd_005", 1'b1, 9'h005, 8'hA5, 1'b0);

        do_op("wr_003", 1'b0, 9'h003, 8'h11, 1'b0);
        do_op("wr_103", 1'b0, 9'h103, 8'h22, 1'b0);
        do_op("rd_003", 1'b1, 9'h003, 8'h11, 1'b0);
        do_op("rd_103", 1'b1, 9'h103, 8'h22, 1'b0);

        do_op("wr_010", 1'b0, 9'h010, 8'h99, 1'b0);
        do_op("wr_050", 1'b0, 9'h050, 8'h77, 1'b1);
        do_op("rd_050", 1'b1, 9'h050, 8'h00, 1'b1);
        do_op("rd_010a", 1'b1, 9'h010, 8'h99, 1'b0);
        do_op("rd_005b", 1'b1, 9'h005, 8'hA5, 1'b0);

        b_rd[0] = 1'b0; b_addr[0] = 9'h020; b_data[0] = 8'h5A;
        b_rd[1] = 1'b1; b_addr[1] = 9'h020; b_data[1] = 8'h5A;
        b_rd[2] = 1'b0; b_addr[2] = 9'h121; b_data[2] = 8'hC3;
        b_rd[3] = 1'b1; b_addr[3] = 9'h121; b_data[3] = 8'hC3;
        set_req(b_rd[0], b_addr[0], b_data[0]);
        bus.transfer = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_req(b_rd[i+1], b_addr[i+1], b_data[i+1]);
            else bus.transfer = 1'b0;
            @(posedge clk); #1;
            check($sformatf("b2b%0d_mid_data", i), 32'(bus.apb_read_data_out), 32'(model_rdata));
            @(posedge clk); #1;
            if (b_rd[i]) model_rdata = b_data[i];
            model_err = 1'b0;
            check($sformatf("b2b%0d_data", i), 32'(bus.apb_read_data_out), 32'(model_rdata));
            check($sformatf("b2b%0d_err", i), 32'(bus.PSLVERR), 32'(model_err));
            $display("[TB] b2b%0d %s addr=0x%03h data=0x%02h err=%0b", i, b_rd[i] ? "RD" : "WR",
                     b_addr[i], bus.apb_read_data_out, bus.PSLVERR);
        end

        do_op("rd_010b", 1'b1, 9'h010, 8'h99, 1'b0);
        set_req(1'b0, 9'h010, 8'h3C);
        bus.transfer = 1'b1;
        @(posedge clk); #1;
        bus.transfer = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_rst_data", 32'(bus.apb_read_data_out), 32'h0);
        check("abort_rst_err", 32'(bus.PSLVERR), 32'h0);
        @(posedge clk); #1;
        check("abort_post_data", 32'(bus.apb_read_data_out), 32'h0);
        check("abort_post_state", 32'(dut.u_master.state_q), 32'(IDLE));
        $display("[TB] abort WR addr=0x010 data=0x3C by reset in ACCESS");
        rst_n       = 1'b1;
        model_rdata = 8'h00;
        model_err   = 1'b0;
        do_op("rd_010c", 1'b1, 9'h010, 8'h99, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_top.md
# apb_top

Single-clock APB subsystem: an APB3 master FSM driving two zero-wait-state APB slaves with local byte memories. Test-side and system-side logic issue simple transfer requests (write or read, 9-bit address, 8-bit data) without handling APB phases. Read data and the slave error flag return on registered outputs. The block is the DUT behind the team's APB verification interface.

## Interface
- Parameters:
- `SLV_DEPTH`, default 64: bytes per slave memory; legal offsets are 0..SLV_DEPTH-1.
- Ports:
- `PCLK` in 1: system clock; all state updates on its rising edge.
- `PRESETn` in 1: reset, synchronous, active-low.
- `transfer` in 1: request; while high, the master starts or continues transactions.
- `READ_WRITE` in 1: 1 = read, 0 = write.
- `apb_write_paddr` in 9: write address. Bit 8 selects the slave (0 = slave 1, 1 = slave 2); bits 7:0 are the offset.
- `apb_read_paddr` in 9: read address, same map.
- `apb_write_data` in 8: write data.
- `apb_read_data_out` out 8: last read data.
- `PSLVERR` out 1: error status of the last completed transaction.

## Operation
- Master FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - With `transfer`=1 → SETUP. Latch `READ_WRITE`, the selected address, and `apb_write_data` into request registers.
  - With `transfer`=0 → stay in IDLE.
- SETUP: PSEL of the addressed slave = 1, PENABLE = 0 → unconditionally ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1, PREADY = 1 (zero wait), so the transfer completes this cycle.
  - If `transfer`=1 → SETUP, latching a new request.
  - If `transfer`=0 → IDLE.
- PADDR source: `apb_read_paddr` for reads, `apb_write_paddr` for writes. Internal PWRITE = !READ_WRITE.
- Error rule: offset ≥ SLV_DEPTH gives PSLVERR = 1 during ACCESS.
  - An erroring write leaves memory unchanged.
  - An erroring read returns 0x00.
- Write completion: mem[offset] ← data in the selected slave only.
- Read completion: `apb_read_data_out` ← slave PRDATA. A write completion leaves `apb_read_data_out` unchanged.
- `PSLVERR` output is registered at every completion and held until the next completion.
- Reset:
  - Synchronous reset → FSM IDLE; `apb_read_data_out` = 0, `PSLVERR` = 0.
  - Both outputs are also forced to 0 combinationally while `PRESETn`=0, so they read 0 in every cycle reset is sampled low.
  - Memory contents are not reset.

## Timing
- Request sampled at edge E0 (IDLE). SETUP during E0→E1, ACCESS during E1→E2. Completion at E2: memory write, and outputs update after E2.
- Read latency is 2 cycles from the sampling edge.
- Back-to-back requests (`transfer` held high) complete one transaction every 2 cycles.
- Inputs change only between the sampling edge and completion. The request registers isolate the transaction from those changes.
- `PRESETn` low mid-transaction aborts it at the next edge: no memory write, no output update.
- `transfer` dropped during SETUP: the transaction still completes.

## Structure
- Shared package `apb_pkg`:
  - state enum `apb_state_t` {IDLE, SETUP, ACCESS};
  - address and data width constants (ADDR_W=9, DATA_W=8);
  - SLV_DEPTH default.
- Sub-modules:
  - `apb_master`: FSM plus request registers.
  - `apb_slave`: memory with PSEL/PENABLE/PREADY/PSLVERR logic, instantiated twice.
- `apb_top` performs slave decode via bit 8 and PRDATA/PSLVERR muxing.

## Test plan
- Reset: hold `PRESETn`=0 for 3 cycles → `apb_read_data_out`=0x00 and `PSLVERR`=0 in every sampled cycle; FSM in IDLE.
- Write 0xA5 to 0x005, then read 0x005 → `apb_read_data_out`=0xA5 two cycles after the read sample edge; `PSLVERR`=0.
- Slave isolation: write 0x11 to 0x003 and 0x22 to 0x103, then read both → 0x11 and 0x22 respectively.
- Out-of-range: write 0x77 to 0x050 → `PSLVERR`=1. Then read 0x050 → `PSLVERR`=1 and data 0x00. Then read 0x005 → `PSLVERR`=0.
- Back-to-back: hold `transfer` high over 4 alternating write/read ops → one completion every 2 cycles, correct data each time.
- Mid-transaction reset: assert `PRESETn`=0 during ACCESS of a write of 0x3C to 0x010 → location unchanged on readback; outputs 0 during reset.
